shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sequencing controller for the 4-entry byte shift register and its processing-element (PE) stage in the iterative compare/inhibit datapath.
- Loads DEPTH input bytes through a valid/ready handshake, then runs repeated PE-compute / feedback-writeback rounds.
- Stops when at most one nonzero entry remains or the iteration cap is hit, then switches the shift register to final-output mode.

Parameters:
- DEPTH, 4, number of shift-register entries; also the load and writeback shift counts.
- MAX_ITER, 15, maximum compute/writeback rounds before forced termination.
- IDX_W, 2, width of the writeback index; equals clog2(DEPTH).
- IT_W, 4, width of the iteration counter; equals clog2(MAX_ITER+1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begins a new run; sampled only in IDLE and DONE.
- in_valid  input  1  an input byte is presented to the shift register.
- in_ready  output  1  controller accepts the byte this cycle.
- pe_done  input  1  one-cycle pulse: PE results are stable.
- nz_count  input  3  number of nonzero shift-register entries, from the datapath.
- pe_start  output  1  one-cycle pulse that launches the PE computation.
- shift  output  1  shift-register shift enable.
- sel_feedback  output  1  shift-register input mux: 0 = external byte, 1 = PE result.
- wb_idx  output  IDX_W  PE result index driven to the feedback mux during writeback.
- final_output  output  1  selects final-output mode of the shift register.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high while in DONE.
- iter_count  output  IT_W  completed rounds in the current run.

Behaviour:
- Reset (async, any state, including mid-load or mid-writeback):
  - state=IDLE; load_cnt, wb_idx, iter_count = 0.
  - All 1-bit outputs = 0.
  - No shift is issued in the reset cycle.
- States: IDLE, LOAD, CALC, WAIT, WB, CHECK, DONE.
- IDLE: start=1 -> LOAD; load_cnt, iter_count, wb_idx cleared.
- LOAD:
  - in_ready=1 (combinational from state); shift = in_valid & in_ready; sel_feedback=0.
  - Each accepted byte increments load_cnt.
  - Acceptance with load_cnt==DEPTH-1 -> CALC. Exactly DEPTH shifts in total.
  - in_valid low: hold, no shift. No timeout.
- CALC: pe_start=1 for exactly this one cycle -> WAIT.
- WAIT:
  - Hold with shift=0 until pe_done=1 -> WB, wb_idx=0.
  - pe_done in any other state is ignored.
- WB:
  - shift=1 and sel_feedback=1 every cycle; wb_idx increments each cycle.
  - After the cycle with wb_idx==DEPTH-1: wb_idx wraps to 0, iter_count increments, -> CHECK.
  - WB therefore lasts exactly DEPTH cycles.
- CHECK (one cycle, evaluated on post-writeback contents):
  - nz_count<=1 or iter_count==MAX_ITER -> DONE.
  - Otherwise -> CALC.
  - Both conditions true at once -> DONE; no priority difference.
- DONE:
  - final_output=1, done=1, busy=0; iter_count holds its final value.
  - start=1 -> LOAD; final_output drops the next cycle.
  - start held continuously in DONE is treated as a new start.
- iter_count never exceeds MAX_ITER and never wraps.
- start while busy is ignored.
- Latency (no input stalls, pe_done returned d cycles after pe_start):
  - Load: DEPTH cycles.
  - Each round: 1 (CALC) + d (WAIT) + DEPTH (WB) + 1 (CHECK) cycles.
- shift and sel_feedback are Moore outputs of state, except the in_valid term in LOAD. in_ready, shift and sel_feedback are 0 outside LOAD/WB.

Test Plan:
- Reset mid-WB with wb_idx=2: assert rst asynchronously -> state IDLE immediately, shift=0, wb_idx=0, iter_count=0, done=0.
- start, then bytes 0x10,0x20,0x30,0x40 with in_valid gaps of 2 cycles -> exactly 4 shift pulses coincide with in_valid, sel_feedback=0, then one pe_start pulse the cycle after the 4th accept.
- pe_done 3 cycles after pe_start, nz_count=1 at CHECK -> 4 consecutive shifts with wb_idx 0,1,2,3, sel_feedback=1, iter_count=1, then DONE with final_output=1 and done=1.
- nz_count held at 3 -> exactly 15 rounds (15 pe_start pulses), iter_count=15, then DONE. No 16th pe_start.
- pe_done pulsed during LOAD and CHECK, and start pulsed during WAIT -> no state change, no extra shift or pe_start.
- In DONE, pulse start -> LOAD next cycle, final_output=0, iter_count=0. A second full run with nz_count=0 at the first CHECK terminates after 1 round.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Sequencing controller for the byte shift register and PE
//               stage of the iterative compare/inhibit datapath. It loads
//               DEPTH bytes, then runs compute/writeback rounds until at most
//               one nonzero entry remains or MAX_ITER rounds have completed.
//               It then switches the shift register to final-output mode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      begin a new run (honoured in IDLE/DONE only)
//   in_valid     in   1      external byte presented
//   in_ready     out  1      byte accepted this cycle (LOAD)
//   pe_done      in   1      PE results stable (honoured in WAIT only)
//   nz_count     in   3      nonzero entry count from the datapath
//   pe_start     out  1      one-cycle PE launch pulse
//   shift        out  1      shift-register shift enable
//   sel_feedback out  1      shift input mux: 0 = external, 1 = PE result
//   wb_idx       out  IDX_W  PE result index during writeback
//   final_output out  1      final-output mode select
//   busy         out  1      run in progress
//   done         out  1      run finished
//   iter_count   out  IT_W   completed rounds in the current run
// ============================================================================
module shift_seq_ctrl #(
  parameter int DEPTH    = 4,
  parameter int MAX_ITER = 15,
  parameter int IDX_W    = 2,
  parameter int IT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pe_done,
  input  logic [2:0]       nz_count,
  output logic             pe_start,
  output logic             shift,
  output logic             sel_feedback,
  output logic [IDX_W-1:0] wb_idx,
  output logic             final_output,
  output logic             busy,
  output logic             done,
  output logic [IT_W-1:0]  iter_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IT_W-1:0]  c_MAX_ITER = IT_W'(MAX_ITER);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_load_cnt;
  logic [IDX_W-1:0] r_wb_idx;
  logic [IT_W-1:0]  r_iter;

  logic w_accept;
  logic w_start_new;
  logic w_wb_last;
  logic w_finish;

  assign w_accept    = (r_state == S_LOAD) & in_valid;
  assign w_start_new = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_wb_last   = (r_wb_idx == c_LAST_IDX);
  // CHECK sees the counter already advanced by the last WB cycle.
  assign w_finish    = (nz_count <= 3'd1) | (r_iter == c_MAX_ITER);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs (plus the in_valid term of the LOAD shift)
  always_comb begin
    w_next       = r_state;
    in_ready     = 1'b0;
    shift        = 1'b0;
    sel_feedback = 1'b0;
    pe_start     = 1'b0;
    final_output = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        shift    = in_valid;
        if (in_valid && (r_load_cnt == c_LAST_IDX)) w_next = S_CALC;
      end
      S_CALC: begin
        pe_start = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (pe_done) w_next = S_WB;
      end
      S_WB: begin
        shift        = 1'b1;
        sel_feedback = 1'b1;
        if (w_wb_last) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_finish ? S_DONE : S_CALC;
      end
      S_DONE: begin
        busy         = 1'b0;
        done         = 1'b1;
        final_output = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Load, writeback-index and iteration counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_cnt <= '0;
      r_wb_idx   <= '0;
      r_iter     <= '0;
    end else if (w_start_new) begin
      r_load_cnt <= '0;
      r_wb_idx   <= '0;
      r_iter     <= '0;
    end else begin
      if (w_accept) begin
        r_load_cnt <= (r_load_cnt == c_LAST_IDX) ? '0 : r_load_cnt + IDX_W'(1);
      end
      if (r_state == S_WAIT && pe_done) begin
        r_wb_idx <= '0;
      end else if (r_state == S_WB) begin
        if (w_wb_last) begin
          r_wb_idx <= '0;
          // Saturate defensively; CHECK already stops the run at the cap.
          if (r_iter != c_MAX_ITER) r_iter <= r_iter + IT_W'(1);
        end else begin
          r_wb_idx <= r_wb_idx + IDX_W'(1);
        end
      end
    end
  end

  assign wb_idx     = r_wb_idx;
  assign iter_count = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Self-checking bench for shift_seq_ctrl. Run lengths are
//               predicted from per-round nonzero counts by a round-level
//               model; cycle behaviour of each phase is checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

  localparam int DEPTH    = 4;
  localparam int MAX_ITER = 15;
  localparam int IDX_W    = 2;
  localparam int IT_W     = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             pe_done;
  logic [2:0]       nz_count;
  logic             pe_start;
  logic             shift;
  logic             sel_feedback;
  logic [IDX_W-1:0] wb_idx;
  logic             final_output;
  logic             busy;
  logic             done;
  logic [IT_W-1:0]  iter_count;

  shift_seq_ctrl #(
    .DEPTH    (DEPTH),
    .MAX_ITER (MAX_ITER),
    .IDX_W    (IDX_W),
    .IT_W     (IT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pe_done      (pe_done),
    .nz_count     (nz_count),
    .pe_start     (pe_start),
    .shift        (shift),
    .sel_feedback (sel_feedback),
    .wb_idx       (wb_idx),
    .final_output (final_output),
    .busy         (busy),
    .done         (done),
    .iter_count   (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Nonzero count the datapath reports at the CHECK of each round.
  logic [2:0] nz_seq [MAX_ITER];

  // Activity monitor, sampled mid-cycle.
  int n_shift = 0;
  int n_pe    = 0;
  int wb_bad  = 0;
  int wb_exp  = 0;
  always @(negedge clk) begin
    if (rst) begin
      wb_exp = 0;
    end else begin
      if (shift) n_shift++;
      if (pe_start) n_pe++;
      if (shift && sel_feedback) begin
        if (int'(wb_idx) != wb_exp) wb_bad++;
        wb_exp = (wb_exp + 1) % DEPTH;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rounds until the first CHECK that sees <=1 nonzero entries, capped.
  function automatic int model_rounds();
    for (int k = 0; k < MAX_ITER; k++) begin
      if (nz_seq[k] <= 3'd1) return k + 1;
    end
    return MAX_ITER;
  endfunction

  // Called at posedge+1; returns at posedge+1 with the DUT in LOAD.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_bytes(input bit gap2, input bit poke);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    while (acc < DEPTH && cyc < 200) begin
      if (gap2) in_valid = (cyc % 3 == 2);
      else      in_valid = ($urandom_range(0, 2) != 0);
      pe_done = poke && !in_valid;
      @(negedge clk);
      cyc++;
      chk("load_ready", in_ready, 1);
      chk("load_shift", shift, in_valid);
      chk("load_selfb", sel_feedback, 0);
      chk("load_iter", iter_count, 0);
      chk("load_final", final_output, 0);
      chk("load_pestart", pe_start, 0);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pe_done  = 1'b0;
  endtask

  // Drives pe_done/nz_count for each round until DONE; returns at a negedge.
  task automatic run_rounds(input int dfix, input bit poke, output int rounds);
    int r;
    int cyc;
    int d;
    bit fin;
    bit seen;
    r = 0; cyc = 0; fin = 0; seen = 0;
    while (!fin && cyc < 1000) begin
      if (!seen) begin
        @(negedge clk);
        cyc++;
      end
      seen = 0;
      if (done) begin
        fin = 1;
      end else if (pe_start) begin
        r++;
        if (r == 1) chk("first_calc_latency", cyc, 1);
        nz_count = (r <= MAX_ITER) ? nz_seq[r-1] : 3'd3;
        d = (dfix >= 0) ? dfix : int'($urandom_range(0, 4));
        @(posedge clk); #1;
        start = poke;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          chk("wait_shift", shift, 0);
          chk("wait_busy", busy, 1);
          @(posedge clk); #1;
        end
        pe_done = 1'b1;
        @(negedge clk);
        chk("wait_shift", shift, 0);
        @(posedge clk); #1;
        pe_done = 1'b0;
        start   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          @(negedge clk);
          chk("wb_shift", shift, 1);
          chk("wb_selfb", sel_feedback, 1);
          chk("wb_idx", wb_idx, k);
          chk("wb_pestart", pe_start, 0);
          @(posedge clk); #1;
        end
        pe_done = poke;
        @(negedge clk);
        chk("check_shift", shift, 0);
        chk("check_pestart", pe_start, 0);
        chk("check_iter", iter_count, r);
        chk("check_busy", busy, 1);
        @(posedge clk); #1;
        pe_done = 1'b0;
        @(negedge clk);
        cyc++;
        seen = 1;
        chk("round_latency", pe_start | done, 1);
      end
    end
    chk("run_reached_done", fin, 1);
    rounds = r;
  endtask

  task automatic full_run(input int dfix, input bit poke, input bit gap2);
    int s0;
    int p0;
    int rounds;
    int exp_r;
    exp_r = model_rounds();
    s0 = n_shift;
    p0 = n_pe;
    pulse_start();
    load_bytes(gap2, poke);
    chk("load_shift_count", n_shift - s0, DEPTH);
    run_rounds(dfix, poke, rounds);
    chk("rounds", rounds, exp_r);
    chk("pe_start_count", n_pe - p0, exp_r);
    chk("iter_final", iter_count, exp_r);
    chk("total_shifts", n_shift - s0, DEPTH * (1 + exp_r));
    chk("wb_idx_sequence", wb_bad, 0);
    chk("done_flag", done, 1);
    chk("done_final", final_output, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_hold_iter", iter_count, exp_r);
    chk("done_hold", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_wb();
    int c;
    pulse_start();
    load_bytes(0, 0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!pe_start && c < 50);
    chk("rst_test_calc", pe_start, 1);
    nz_count = 3'd3;
    @(posedge clk); #1;
    pe_done = 1'b1;
    @(posedge clk); #1;
    pe_done = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_reset_wbidx", wb_idx, 2);
    chk("pre_reset_shift", shift, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_shift", shift, 0);
    chk("async_rst_wbidx", wb_idx, 0);
    chk("async_rst_iter", iter_count, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_selfb", sel_feedback, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_shift", shift, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    pe_done  = 1'b0;
    nz_count = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_shift", shift, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_pestart", pe_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_final", final_output, 0);
    chk("reset_wbidx", wb_idx, 0);
    chk("reset_iter", iter_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Gapped load, pe_done 3 cycles after pe_start, one nonzero left.
    for (int k = 0; k < MAX_ITER; k++) nz_seq[k] = 3'd1;
    full_run(2, 1'b1, 1'b1);

    // Asynchronous reset in the middle of writeback.
    reset_mid_wb();

    // Never converges: runs to the iteration cap.
    for (int k = 0; k < MAX_ITER; k++) nz_seq[k] = 3'd3;
    full_run(-1, 1'b0, 1'b0);

    // Restart from DONE; converges at the first CHECK.
    for (int k = 0; k < MAX_ITER; k++) nz_seq[k] = 3'($urandom_range(2, 4));
    nz_seq[0] = 3'd0;
    full_run(-1, 1'b1, 1'b0);

    // Random convergence points and handshake timing.
    for (int run = 0; run < 6; run++) begin
      for (int k = 0; k < MAX_ITER; k++) begin
        if ($urandom_range(0, 5) == 0) nz_seq[k] = 3'($urandom_range(0, 1));
        else                           nz_seq[k] = 3'($urandom_range(2, 4));
      end
      full_run(-1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
